// File: rtl/serial_buffer_pkg.sv
// ============================================================================
// Module   : serial_buffer_pkg
// Brief    : Shared types and constants for the serial in/out buffer link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    SEP1 = 3'd2,
    DATA = 3'd3,
    SEP2 = 3'd4,
    STOP = 3'd5
  } state_e;

  localparam int C_SIZE_A    = 7;
  localparam int C_SIZE_D    = 8;
  // start + A + separator + D + separator + stop
  localparam int C_FRAME_LEN = C_SIZE_A + C_SIZE_D + 4;

endpackage

`default_nettype wire

// File: rtl/serial_in_buffer_if.sv
// ============================================================================
// Module   : serial_in_buffer_if
// Brief    : Serial line inputs and parallel frame outputs of the receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_in_buffer_if
  import serial_buffer_pkg::*;
#(
  parameter int SIZE_A = C_SIZE_A,
  parameter int SIZE_D = C_SIZE_D
);
  logic              SerC;
  logic              SerD;
  logic [SIZE_A-1:0] A_out;
  logic [SIZE_D-1:0] D_out;
  logic              Valid;
  logic              Busy;
  logic              Frame_err;

  modport slave  (input SerC, SerD, output A_out, D_out, Valid, Busy, Frame_err);
  modport master (output SerC, SerD, input A_out, D_out, Valid, Busy, Frame_err);
endinterface

`default_nettype wire

// File: rtl/serial_in_sync.sv
// ============================================================================
// Module   : serial_in_sync
// Brief    : Two-flop synchronisers for SerC/SerD plus SerC falling-edge strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_in_sync (
  input  wire logic clk_in,
  input  wire logic reset_n,
  input  wire logic i_ser_c,
  input  wire logic i_ser_d,
  output logic      o_ser_d,
  output logic      o_bs
);
  logic [1:0] r_c_sync;
  logic [1:0] r_d_sync;
  logic       r_c_hist;

  // Reset to the idle-high line level so no false strobe follows reset.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_c_sync <= 2'b11;
      r_d_sync <= 2'b11;
      r_c_hist <= 1'b1;
    end else begin
      r_c_sync <= {r_c_sync[0], i_ser_c};
      r_d_sync <= {r_d_sync[0], i_ser_d};
      r_c_hist <= r_c_sync[1];
    end
  end

  assign o_bs    = r_c_hist & ~r_c_sync[1];
  assign o_ser_d = r_d_sync[1];
endmodule

`default_nettype wire

// File: rtl/serial_in_buffer.sv
// ============================================================================
// Module   : serial_in_buffer
// Brief    : Serial frame receiver; optional stop-bit check under the macro
//            SERIAL_IN_FRAME_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_in_buffer
  import serial_buffer_pkg::*;
#(
  parameter int SIZE_A  = C_SIZE_A,
  parameter int SIZE_D  = C_SIZE_D,
  parameter int TIMEOUT = 64
) (
  input wire logic           clk_in,
  input wire logic           reset_n,
  serial_in_buffer_if.slave  bus
);
  localparam int CNT_W = $clog2((SIZE_A > SIZE_D ? SIZE_A : SIZE_D) + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic              w_bs;
  logic              w_bit;
  state_e            r_state,   w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [TO_W-1:0]   r_to_cnt,  w_to_cnt_nxt;
  logic [SIZE_A-1:0] r_sh_a,    w_sh_a_nxt;
  logic [SIZE_D-1:0] r_sh_d,    w_sh_d_nxt;
  logic [SIZE_A-1:0] r_a_out,   w_a_out_nxt;
  logic [SIZE_D-1:0] r_d_out,   w_d_out_nxt;
  logic              r_valid,   w_valid_nxt;
  logic              r_err,     w_err_nxt;

  serial_in_sync u_sync (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .i_ser_c (bus.SerC),
    .i_ser_d (bus.SerD),
    .o_ser_d (w_bit),
    .o_bs    (w_bs)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_sh_a    <= '0;
      r_sh_d    <= '0;
      r_a_out   <= '0;
      r_d_out   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_sh_a    <= w_sh_a_nxt;
      r_sh_d    <= w_sh_d_nxt;
      r_a_out   <= w_a_out_nxt;
      r_d_out   <= w_d_out_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sh_a_nxt    = r_sh_a;
    w_sh_d_nxt    = r_sh_d;
    w_a_out_nxt   = r_a_out;
    w_d_out_nxt   = r_d_out;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    w_to_cnt_nxt  = (r_state == IDLE || w_bs) ? '0 : r_to_cnt + 1'b1;

    // A strobe always takes priority over an expiring timeout.
    if (w_bs) begin
      case (r_state)
        IDLE: if (!w_bit) begin
          w_state_nxt   = ADDR;
          w_bit_cnt_nxt = CNT_W'(SIZE_A - 1);
        end
        ADDR: begin
          w_sh_a_nxt = {r_sh_a[SIZE_A-2:0], w_bit};
          if (r_bit_cnt == '0) w_state_nxt = SEP1;
          else                 w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end
        SEP1: begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = CNT_W'(SIZE_D - 1);
        end
        DATA: begin
          w_sh_d_nxt = {r_sh_d[SIZE_D-2:0], w_bit};
          if (r_bit_cnt == '0) w_state_nxt = SEP2;
          else                 w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end
        SEP2: w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
`ifdef SERIAL_IN_FRAME_CHECK_EN
          if (w_bit) begin
            w_err_nxt = 1'b1;
          end else begin
            w_a_out_nxt = r_sh_a;
            w_d_out_nxt = r_sh_d;
            w_valid_nxt = 1'b1;
          end
`else
          w_a_out_nxt = r_sh_a;
          w_d_out_nxt = r_sh_d;
          w_valid_nxt = 1'b1;
`endif
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE && r_to_cnt == TO_W'(TIMEOUT - 1)) begin
      w_state_nxt  = IDLE;
      w_err_nxt    = 1'b1;
      w_to_cnt_nxt = '0;
    end
  end

  assign bus.A_out     = r_a_out;
  assign bus.D_out     = r_d_out;
  assign bus.Valid     = r_valid;
  assign bus.Frame_err = r_err;
  assign bus.Busy      = (r_state != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_serial_in_buffer.sv
// ============================================================================
// Module   : tb_serial_in_buffer
// Brief    : Directed plus random frame bench for serial_in_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_in_buffer;
  localparam int TO = 64;
`ifdef SERIAL_IN_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  serial_in_buffer_if #(.SIZE_A(7), .SIZE_D(8)) bus ();

  serial_in_buffer #(.SIZE_A(7), .SIZE_D(8), .TIMEOUT(TO)) dut (
    .clk_in  (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Observation side: every Valid pulse and Frame_err pulse is recorded.
  logic [14:0] got_q[$];
  logic [14:0] exp_q[$];
  int err_seen = 0, exp_err = 0, err_cyc = 0, fall_cyc = 0;
  int run = 0, max_run = 0;

  always @(negedge clk) begin
    if (bus.Valid === 1'b1) begin
      got_q.push_back({bus.A_out, bus.D_out});
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (bus.Frame_err === 1'b1) begin
      err_seen++;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit z);
    @(posedge clk); #1;
    bus.SerD = z ? 1'bz : b;
    repeat (3) @(posedge clk); #1;
    bus.SerC = 1'b0;
    fall_cyc = cyc;
    repeat (3) @(posedge clk); #1;
    bus.SerC = 1'b1;
    @(posedge clk);
  endtask

  // Reference: a frame yields (A,D) unless the stop check rejects it.
  task automatic send_frame(input logic [6:0] a, input logic [7:0] d,
                            input logic stp, input bit z);
    send_bit(1'b0, 1'b0);
    for (int i = 6; i >= 0; i--) send_bit(a[i], 1'b0);
    @(negedge clk);
    chk("busy_mid_frame", {31'd0, bus.Busy}, 32'd1);
    send_bit(1'b1, z);
    for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
    send_bit(1'b1, z);
    send_bit(stp, 1'b0);
    bus.SerD = 1'b1;
    if (CHK && stp) exp_err++;
    else exp_q.push_back({a, d});
  endtask

  task automatic check_results(input string tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_nvalid"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_data"}, {17'd0, got_q.pop_front()}, {17'd0, exp_q.pop_front()});
    got_q.delete();
    exp_q.delete();
    chk({tag, "_nerr"}, err_seen, exp_err);
    chk({tag, "_busy_end"}, {31'd0, bus.Busy}, 32'd0);
  endtask

  initial begin
    int k, start_err, delta;
    logic [6:0] ra;
    logic [7:0] rd;
    bus.SerC = 1'b1;
    bus.SerD = 1'b1;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_a", {25'd0, bus.A_out}, 32'd0);
    chk("rst_d", {24'd0, bus.D_out}, 32'd0);
    chk("rst_valid", {31'd0, bus.Valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_err", {31'd0, bus.Frame_err}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    send_frame(7'h7F, 8'hFF, 1'b0, 1'b0);
    check_results("all_ones");

    max_run = 0;
    send_frame(7'h41, 8'h9F, 1'b0, 1'b1);
    check_results("sep_z");
    chk("valid_one_cycle", max_run, 1);

    send_frame(7'h01, 8'h80, 1'b0, 1'b0);
    send_frame(7'h55, 8'hAA, 1'b0, 1'b0);
    check_results("back_to_back");

    // Five bits then SerC stays high.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    start_err = err_seen;
    k = 0;
    while (err_seen == start_err && k < TO + 40) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    exp_err++;
    chk("timeout_err", err_seen, exp_err);
    delta = err_cyc - fall_cyc;
    chk("timeout_delay", {31'd0, (delta >= TO + 1 && delta <= TO + 5)}, 32'd1);
    chk("timeout_busy", {31'd0, bus.Busy}, 32'd0);
    chk("timeout_a_hold", {25'd0, bus.A_out}, 32'h55);
    chk("timeout_d_hold", {24'd0, bus.D_out}, 32'hAA);
    chk("timeout_novalid", got_q.size(), 0);

    send_frame(7'h12, 8'h34, 1'b1, 1'b0);
    check_results("bad_stop");

    // Abort partway through field D with a one-cycle reset.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_a", {25'd0, bus.A_out}, 32'd0);
    chk("midrst_d", {24'd0, bus.D_out}, 32'd0);
    chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("midrst_valid", {31'd0, bus.Valid}, 32'd0);
    repeat (3) @(posedge clk);
    chk("midrst_noerr", err_seen, exp_err);
    send_frame(7'h3C, 8'hC3, 1'b0, 1'b0);
    check_results("after_rst");

    for (int n = 0; n < 8; n++) begin
      ra = 7'($urandom);
      rd = 8'($urandom);
      send_frame(ra, rd, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
      check_results("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/serial_in_buffer.md
# serial_in_buffer

Receiving end of the team's 19-bit serial out buffer link. The block recovers one frame from the `SerD`/`SerC` pair and presents the fields in parallel with a one-cycle valid pulse:

- frame format: start `0`, field A (MSB first), separator, field D (MSB first), separator, stop `0`;
- `SerC` idles high and pulses low once per bit;
- `SerD` idles high.

It sits in the consumer's clock domain. `clk_in` must run at least 4x the serial bit rate.

## Interface

Parameters:

- `SIZE_A`, 7, width of field A
- `SIZE_D`, 8, width of field D
- `TIMEOUT`, 64, max `clk_in` cycles between bit strobes inside a frame before abort

Ports:

- `clk_in` input 1: sole clock
- `reset_n` input 1: reset, synchronous, active-low
- `SerC` input 1: serial bit clock from transmitter; asynchronous to `clk_in`
- `SerD` input 1: serial data; separator bits may be Z/X
- `A_out` output SIZE_A: last received field A
- `D_out` output SIZE_D: last received field D
- `Valid` output 1: one-cycle pulse, new `A_out`/`D_out` present
- `Busy` output 1: frame reception in progress
- `Frame_err` output 1: one-cycle pulse on aborted or malformed frame

## Operation

Input synchronisation and bit strobe:
- `SerC` and `SerD` each pass through 2 sync flops, plus 1 history flop on `SerC`.
- Bit strobe `bs` = synced `SerC` falling edge (history=1, sync2=0). The falling edge sits mid-bit, away from transmitter data changes.
- On `bs`, the synced `SerD` is the bit value.

FSM states, with a bit counter and a timeout counter:
- IDLE: `Busy`=0. `bs` with bit=0 → ADDR, counter=SIZE_A-1. `bs` with bit=1 is ignored.
- ADDR: each `bs` shifts the bit into the A shift register. At counter 0 → SEP1, else decrement.
- SEP1: one `bs`, bit discarded (Z tolerated) → DATA, counter=SIZE_D-1.
- DATA: like ADDR into the D shift register; at counter 0 → SEP2.
- SEP2: one `bs`, discarded → STOP.
- STOP: one `bs`. Load `A_out`/`D_out` from the shift registers, pulse `Valid` → IDLE.

Timeout counter:
- Cleared on every `bs`; increments each cycle outside IDLE.
- Reaching TIMEOUT → IDLE, shift registers discarded, `Frame_err` pulse, `A_out`/`D_out` unchanged.

Output behaviour:
- `A_out`/`D_out` hold their value until the next good frame. There is no backpressure; the consumer must take the data on `Valid`.
- `Busy`=1 in every state except IDLE.

## Timing

- Reset (`reset_n`=0 at a `clk_in` edge) clears all outputs and state:
  - `A_out`=0, `D_out`=0, `Valid`=0, `Busy`=0, `Frame_err`=0, FSM=IDLE;
  - sync flops set to 1 (idle level).
- Reset mid-frame abandons the frame silently, with no `Frame_err`.
- Strobe latency: `bs` is asserted 3 `clk_in` cycles after the `SerC` falling edge reaches the pin.
- `Valid` rises in the cycle after the STOP `bs`; `A_out`/`D_out` update in that same cycle.
- Input requirements:
  - `SerC` low and high phases each ≥2 `clk_in` cycles;
  - `SerD` stable ≥3 cycles around the `SerC` falling edge.
- Back-to-back frames: a start bit on the `bs` immediately following STOP is accepted. Zero idle bits are allowed.
- Timeout and `bs` in the same cycle: `bs` wins and the counter clears.

## Configuration

- `SERIAL_IN_FRAME_CHECK_EN` defined:
  - at IDLE→ADDR, the start bit is qualified as above;
  - in STOP, bit=1 means a bad stop: no `Valid`, `Frame_err` pulse, outputs unchanged, → IDLE.
- Undefined:
  - stop bit value is ignored and every completed frame gives `Valid`;
  - `Frame_err` pulses only on timeout.

## Structure

- Shared package `serial_buffer_pkg` holds:
  - FSM state enum (IDLE, ADDR, SEP1, DATA, SEP2, STOP);
  - default SIZE_A/SIZE_D;
  - frame length constant SIZE_A+SIZE_D+4.
- The transmitter uses the same package.
- One sub-module, `serial_in_sync`: 2-flop synchroniser plus history flop, outputting synced `SerD` and `bs`.
- FSM, counters and shift registers stay in the top level.

## Test plan

- Frame A=7'h7F, D=8'hFF, stop 0 → one `Valid` pulse; `A_out`=7'h7F, `D_out`=8'hFF; `Frame_err`=0; `Busy` high from start bit to STOP.
- A=7'h41, D=8'h9F with both separators driven Z → `A_out`=7'h41, `D_out`=8'h9F, `Valid`=1 for exactly one cycle.
- Two frames back-to-back (7'h01/8'h80 then 7'h55/8'hAA) → two `Valid` pulses with the correct values in order.
- `SerC` held high after 5 bits of a frame → `Frame_err` pulse TIMEOUT cycles after the last `bs`; `A_out`/`D_out` keep previous values; `Busy`=0.
- Stop bit 1 with A=7'h12, D=8'h34:
  - macro defined → `Frame_err`, no `Valid`;
  - macro undefined → `Valid` with 7'h12/8'h34.
- `reset_n`=0 for one cycle mid-DATA → all outputs 0, no `Frame_err`; the next full frame is received correctly.
